// File: rtl/key_pkg.sv
// Shared types and default timing for the multi-channel key autorepeat block.
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } key_state_e;

  localparam int unsigned CLK_HZ         = 50_000_000;
  localparam int unsigned DEBOUNCE_MS    = 5;
  localparam int unsigned FIRST_DELAY_MS = 200;
  localparam int unsigned REPEAT_MS      = 50;

  localparam int unsigned DEF_CNT_W         = 32;
  localparam int unsigned DEF_DEBOUNCE      = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned DEF_FIRST_DELAY   = CLK_HZ / 1000 * FIRST_DELAY_MS;
  localparam int unsigned DEF_REPEAT_PERIOD = CLK_HZ / 1000 * REPEAT_MS;

endpackage

// File: rtl/key_repeat_ch.sv
// One key channel: 2-flop synchroniser, debounce counter and press/autorepeat FSM.
module key_repeat_ch
  import key_pkg::*;
#(
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned DEBOUNCE      = DEF_DEBOUNCE,
  parameter int unsigned FIRST_DELAY   = DEF_FIRST_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic RST,
  input  logic en,
  input  logic key_in,
  output logic held,
  output logic r
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] FD_LAST  = CNT_W'(FIRST_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] rcnt;
  key_state_e       state;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  // Level only flips after DEBOUNCE consecutive disagreeing samples.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      held <= 1'b0;
      dcnt <= '0;
    end else if (sync2 != held) begin
      if (dcnt == DB_LAST) begin
        held <= ~held;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + CNT_ONE;
      end
    end else begin
      dcnt <= '0;
    end
  end

  // Release or disable overrides every transition and returns to idle.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      rcnt  <= '0;
      r     <= 1'b0;
    end else if (!held || !en) begin
      state <= ST_IDLE;
      rcnt  <= '0;
      r     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_DELAY;
          rcnt  <= '0;
          r     <= 1'b1;
        end
        ST_DELAY: begin
          if (rcnt == FD_LAST) begin
            state <= ST_REPEAT;
            rcnt  <= '0;
            r     <= 1'b1;
          end else begin
            rcnt  <= rcnt + CNT_ONE;
            r     <= 1'b0;
          end
        end
        ST_REPEAT: begin
          if (rcnt == RP_LAST) begin
            rcnt <= '0;
            r    <= 1'b1;
          end else begin
            rcnt <= rcnt + CNT_ONE;
            r    <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          rcnt  <= '0;
          r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_repeat_array.sv
// N independent debounced autorepeat key channels with optional lowest-index exclusivity.
module key_repeat_array
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS        = 4,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned DEBOUNCE      = DEF_DEBOUNCE,
  parameter int unsigned FIRST_DELAY   = DEF_FIRST_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter bit          EXCLUSIVE     = 1'b0
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              en,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] pulse,
  output logic [N_KEYS-1:0] held
);

  logic [N_KEYS-1:0] held_w;
  logic [N_KEYS-1:0] r_w;
  logic [N_KEYS-1:0] mask_c;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_repeat_ch #(
      .CNT_W        (CNT_W),
      .DEBOUNCE     (DEBOUNCE),
      .FIRST_DELAY  (FIRST_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk   (clk),
      .RST   (RST),
      .en    (en),
      .key_in(key_in[i]),
      .held  (held_w[i]),
      .r     (r_w[i])
    );
  end

  // Isolate the lowest set bit of held; masked channels keep their timing.
  if (EXCLUSIVE) begin : g_excl
    assign mask_c = held_w & (~held_w + N_KEYS'(1));
  end else begin : g_all
    assign mask_c = '1;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      pulse <= '0;
    end else begin
      pulse <= r_w & mask_c;
    end
  end

  assign held = held_w;

endmodule

// File: tb/tb_key_repeat_array.sv
// Bench for key_repeat_array: plain and exclusive instances against a timing-rule reference model.
module tb_key_repeat_array;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int FD = 10;
  localparam int RP = 3;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] key;
    int         ncyc;
    logic [3:0] exp_held;
    logic [3:0] exp_pulse;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [N-1:0] key_in;
  logic [N-1:0] pulse_n, held_n, pulse_x, held_x;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [N-1:0] m_s1, m_s2, m_held, m_r, m_pn, m_px;
  logic [7:0]   m_hist [N];
  int           m_since[N];
  int           m_run  [N];

  always #5 clk = ~clk;

  key_repeat_array #(.N_KEYS(N), .CNT_W(8), .DEBOUNCE(D), .FIRST_DELAY(FD),
                     .REPEAT_PERIOD(RP), .EXCLUSIVE(1'b0)) dut_n (
    .clk(clk), .RST(rst), .en(en), .key_in(key_in), .pulse(pulse_n), .held(held_n));

  key_repeat_array #(.N_KEYS(N), .CNT_W(8), .DEBOUNCE(D), .FIRST_DELAY(FD),
                     .REPEAT_PERIOD(RP), .EXCLUSIVE(1'b1)) dut_x (
    .clk(clk), .RST(rst), .en(en), .key_in(key_in), .pulse(pulse_x), .held(held_x));

  task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_held = '0; m_r = '0; m_pn = '0; m_px = '0;
    for (int i = 0; i < N; i++) begin
      m_hist[i] = '0; m_since[i] = 0; m_run[i] = 0;
    end
  endtask

  // One clock edge: a press fires at active-run 1, then 1+FD, then every RP.
  task automatic model_step();
    logic [N-1:0] held_prev, r_prev, xmask;
    logic act, agree;
    if (rst) begin
      model_reset();
      return;
    end
    held_prev = m_held;
    r_prev    = m_r;
    xmask     = '0;
    for (int i = N - 1; i >= 0; i--)
      if (held_prev[i]) begin xmask = '0; xmask[i] = 1'b1; end
    m_pn = r_prev;
    m_px = r_prev & xmask;
    for (int i = 0; i < N; i++) begin
      act      = held_prev[i] & en;
      m_run[i] = act ? m_run[i] + 1 : 0;
      m_r[i]   = act && (m_run[i] == 1 ||
                 (m_run[i] >= 1 + FD && ((m_run[i] - 1 - FD) % RP) == 0));
      m_hist[i] = {m_hist[i][6:0], m_s2[i]};
      if (m_since[i] < 1000) m_since[i]++;
      agree = 1'b1;
      for (int k = 0; k < D; k++)
        if (m_hist[i][k] == held_prev[i]) agree = 1'b0;
      if (agree && m_since[i] >= D) begin
        m_held[i]  = ~held_prev[i];
        m_since[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = key_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model_pulse", pulse_n, m_pn);
    check("model_held", held_n, m_held);
    check("model_pulse_x", pulse_x, m_px);
    check("model_held_x", held_x, m_held);
  endtask

  vec_t         tbl[16];
  logic [N-1:0] acc, acc2;
  int           burst;
  logic         prev2;

  initial begin
    rst = 1'b1; en = 1'b1; key_in = '0;
    model_reset();

    tbl[0]  = '{1'b1, 1'b1, 4'hF, 3, 4'h0, 4'h0};
    tbl[1]  = '{1'b0, 1'b1, 4'hF, 5, 4'h0, 4'h0};
    tbl[2]  = '{1'b0, 1'b1, 4'hF, 1, 4'hF, 4'h0};
    tbl[3]  = '{1'b0, 1'b1, 4'hF, 1, 4'hF, 4'h0};
    tbl[4]  = '{1'b0, 1'b1, 4'hF, 1, 4'hF, 4'hF};
    tbl[5]  = '{1'b0, 1'b1, 4'hF, 1, 4'hF, 4'h0};
    tbl[6]  = '{1'b0, 1'b1, 4'hF, 9, 4'hF, 4'hF};
    tbl[7]  = '{1'b0, 1'b1, 4'hF, 2, 4'hF, 4'h0};
    tbl[8]  = '{1'b0, 1'b1, 4'hF, 1, 4'hF, 4'hF};
    tbl[9]  = '{1'b0, 1'b1, 4'hF, 2, 4'hF, 4'h0};
    tbl[10] = '{1'b0, 1'b1, 4'h0, 1, 4'hF, 4'hF};
    tbl[11] = '{1'b0, 1'b1, 4'h0, 4, 4'hF, 4'h0};
    tbl[12] = '{1'b0, 1'b1, 4'h0, 1, 4'h0, 4'h0};
    tbl[13] = '{1'b0, 1'b1, 4'h0, 1, 4'h0, 4'hF};
    tbl[14] = '{1'b0, 1'b1, 4'h0, 1, 4'h0, 4'h0};
    tbl[15] = '{1'b0, 1'b1, 4'h0, 5, 4'h0, 4'h0};

    @(negedge clk);
    for (int v = 0; v < 16; v++) begin
      rst = tbl[v].rst; en = tbl[v].en; key_in = tbl[v].key;
      repeat (tbl[v].ncyc) tick();
      check($sformatf("tbl%0d_held", v), held_n, tbl[v].exp_held);
      check($sformatf("tbl%0d_pulse", v), pulse_n, tbl[v].exp_pulse);
    end

    // bounce on key1: 3 high, 1 low, 3 high never accepted
    acc = '0;
    foreach (tbl[v]) ;
    key_in = 4'b0010; repeat (3) begin tick(); acc |= held_n | pulse_n; end
    key_in = 4'b0000; tick(); acc |= held_n | pulse_n;
    key_in = 4'b0010; repeat (3) begin tick(); acc |= held_n | pulse_n; end
    key_in = 4'b0000; repeat (8) begin tick(); acc |= held_n | pulse_n; end
    check("bounce_quiet", acc, 4'b0000);
    acc = '0; acc2 = '0;
    key_in = 4'b0010; repeat (4) begin tick(); acc |= held_n; acc2 |= pulse_n; end
    key_in = 4'b0000; repeat (12) begin tick(); acc |= held_n; acc2 |= pulse_n; end
    check("bounce_accept_held", acc, 4'b0010);
    check("bounce_accept_pulse", acc2, 4'b0010);

    // exclusive: keys 1 and 2 together, then key1 released
    acc = '0; acc2 = '0;
    key_in = 4'b0110; repeat (30) begin tick(); acc |= pulse_x; acc2 |= pulse_n; end
    check("excl_both_x", acc, 4'b0010);
    check("excl_both_n", acc2, 4'b0110);
    acc = '0; burst = 0; prev2 = 1'b0;
    key_in = 4'b0100;
    repeat (20) begin
      tick();
      acc |= pulse_x;
      if (prev2 && pulse_x[2]) burst++;
      prev2 = pulse_x[2];
    end
    check("excl_handover", acc & 4'b0100, 4'b0100);
    check("excl_no_burst", 4'(burst), 4'd0);
    key_in = 4'b0000; repeat (12) tick();

    // en dropped while key3 repeats, then restored
    key_in = 4'b1000; repeat (25) tick();
    en = 1'b0; tick();
    acc = '0; repeat (4) begin tick(); acc |= pulse_n | pulse_x; end
    check("en_stop", acc, 4'b0000);
    en = 1'b1; tick();
    check("en_resume_gap", pulse_n, 4'b0000);
    tick();
    check("en_resume", pulse_n, 4'b1000);
    repeat (9) tick();
    check("en_first_gap", pulse_n, 4'b0000);
    tick();
    check("en_first_repeat", pulse_n, 4'b1000);
    key_in = 4'b0000; repeat (12) tick();

    // reset mid-delay on key0 with key still pressed
    key_in = 4'b0001; repeat (10) tick();
    check("pre_rst_held", held_n, 4'b0001);
    rst = 1'b1; #1;
    check("rst_async_held", held_n, 4'b0000);
    check("rst_async_pulse", pulse_n, 4'b0000);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("rst_redo_held_lo", held_n, 4'b0000);
    tick();
    check("rst_redo_held_hi", held_n, 4'b0001);
    tick(); tick();
    check("rst_redo_pulse", pulse_n, 4'b0001);
    key_in = 4'b0000; repeat (12) tick();

    // randomized levels, enables and occasional reset
    for (int it = 0; it < 200; it++) begin
      key_in = 4'($urandom);
      en     = ($urandom_range(0, 9) != 0);
      rst    = ($urandom_range(0, 40) == 0);
      repeat ($urandom_range(1, 30)) tick();
    end
    rst = 1'b0; en = 1'b1; key_in = '0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
